// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr accesses, trap entry/mret state, optional cycle/instret counters.
// Counters are built only when CSR_COUNTERS_EN is defined.
module csr_file #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter int unsigned     HART_ID     = 0,
    parameter logic [XLEN-1:0] MISA_VAL    = XLEN'(32'h40000100)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rd,
    input  logic            i_wr,
    input  logic            i_set,
    input  logic            i_clr,
    input  logic [11:0]     i_adr,
    input  logic [XLEN-1:0] i_wr_data,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_illegal,
    input  logic            i_retire,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_val,
    input  logic            i_mret,
    output logic [XLEN-1:0] o_mtvec,
    output logic [XLEN-1:0] o_mepc,
    output logic            o_mie
);

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;

    logic            impl;
    logic            wop;
    logic            ro_viol;
    logic            we;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wdata;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`else
    logic unused_retire;
    assign unused_retire = i_retire;
`endif

    always_comb begin
        impl   = 1'b1;
        rd_val = '0;
        case (i_adr)
            12'h300: begin
                rd_val[12:11] = 2'b11;
                rd_val[7]     = mpie_q;
                rd_val[3]     = mie_q;
            end
            12'h301: rd_val = MISA_VAL;
            12'hF14: rd_val = XLEN'(HART_ID);
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
`ifdef CSR_COUNTERS_EN
            12'hB00: rd_val = XLEN'(mcycle_q[31:0]);
            12'hB80: rd_val = XLEN'(mcycle_q[63:32]);
            12'hB02: rd_val = XLEN'(minstret_q[31:0]);
            12'hB82: rd_val = XLEN'(minstret_q[63:32]);
`else
            12'hB00, 12'hB80,
            12'hB02, 12'hB82: rd_val = '0;
`endif
            default: impl = 1'b0;
        endcase
    end

    assign wop       = i_wr | i_set | i_clr;
    assign ro_viol   = (i_adr[11:10] == 2'b11) &
                       (i_wr | ((i_set | i_clr) & (|i_wr_data)));
    assign o_illegal = (i_rd | wop) & (~impl | ro_viol);
    assign o_rd_data = rd_val;
    assign we        = wop & ~o_illegal;

    always_comb begin
        if (i_wr)
            wdata = i_wr_data;
        else if (i_set)
            wdata = rd_val | i_wr_data;
        else
            wdata = rd_val & ~i_wr_data;
    end

    // Apply in rising priority: CSR write, then mret, then trap overrides.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (we) begin
            case (i_adr)
                12'h300: begin
                    mie_d  = wdata[3];
                    mpie_d = wdata[7];
                end
                12'h305: mtvec_d = {wdata[XLEN-1:2],
                                    wdata[1] ? mtvec_q[1:0] : wdata[1:0]};
                12'h340: mscratch_d = wdata;
                12'h341: mepc_d     = {wdata[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = wdata;
                12'h343: mtval_d    = wdata;
                default: ;
            endcase
        end
        if (i_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if (i_trap) begin
            mepc_d   = {i_trap_pc[XLEN-1:2], 2'b00};
            mcause_d = i_trap_cause;
            mtval_d  = i_trap_val;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to either half replaces the increment, with no carry between halves.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, i_retire};
        if (we) begin
            case (i_adr)
                12'hB00: mcycle_d   = {mcycle_q[63:32], wdata[31:0]};
                12'hB80: mcycle_d   = {wdata[31:0], mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wdata[31:0]};
                12'hB82: minstret_d = {wdata[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    assign o_mtvec = i_rst ? MTVEC_RESET : mtvec_q;
    assign o_mepc  = i_rst ? '0 : mepc_q;
    assign o_mie   = ~i_rst & mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Randomised bench for csr_file against an architectural model of the CSRs.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        i_rst, i_rd, i_wr, i_set, i_clr;
    logic [11:0] i_adr;
    logic [31:0] i_wr_data;
    logic [31:0] o_rd_data;
    logic        o_illegal;
    logic        i_retire, i_trap, i_mret;
    logic [31:0] i_trap_pc, i_trap_cause, i_trap_val;
    logic [31:0] o_mtvec, o_mepc;
    logic        o_mie;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    bit              m_mie, m_mpie;
    logic [31:0]     m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    longint unsigned m_cyc, m_ins;

    always #5 clk = ~clk;

    csr_file dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_rd         (i_rd),
        .i_wr         (i_wr),
        .i_set        (i_set),
        .i_clr        (i_clr),
        .i_adr        (i_adr),
        .i_wr_data    (i_wr_data),
        .o_rd_data    (o_rd_data),
        .o_illegal    (o_illegal),
        .i_retire     (i_retire),
        .i_trap       (i_trap),
        .i_trap_pc    (i_trap_pc),
        .i_trap_cause (i_trap_cause),
        .i_trap_val   (i_trap_val),
        .i_mret       (i_mret),
        .o_mtvec      (o_mtvec),
        .o_mepc       (o_mepc),
        .o_mie        (o_mie)
    );

    // {implemented, value} as the architecture defines each address
    function automatic logic [32:0] mread(input logic [11:0] a);
        logic [31:0] st;
        st = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
        case (a)
            12'h300: return {1'b1, st};
            12'h301: return {1'b1, 32'h40000100};
            12'hF14: return {1'b1, 32'h0};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
`ifdef CSR_COUNTERS_EN
            12'hB00: return {1'b1, m_cyc[31:0]};
            12'hB80: return {1'b1, m_cyc[63:32]};
            12'hB02: return {1'b1, m_ins[31:0]};
            12'hB82: return {1'b1, m_ins[63:32]};
`else
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return {1'b1, 32'h0};
`endif
            default: return 33'h0;
        endcase
    endfunction

    function automatic bit exp_illegal();
        logic [32:0] r;
        bit acc, ro;
        r   = mread(i_adr);
        acc = i_rd || i_wr || i_set || i_clr;
        ro  = (i_adr[11:10] == 2'b11) &&
              (i_wr || ((i_set || i_clr) && i_wr_data != 0));
        return acc && (!r[32] || ro);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [32:0]     r;
        logic [31:0]     wd, v;
        bit              w, nmie, nmpie;
        logic [31:0]     ntvec, nscr, nepc, ncause, ntval;
        longint unsigned cyc, ins;
        if (i_rst) begin
            m_mie <= 0; m_mpie <= 0;
            m_mtvec <= 32'h0; m_mscratch <= 0;
            m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
            m_cyc <= 0; m_ins <= 0;
        end else begin
            r = mread(i_adr);
            v = r[31:0];
            w = (i_wr || i_set || i_clr) && !exp_illegal();
            wd = i_wr ? i_wr_data : (i_set ? (v | i_wr_data) : (v & ~i_wr_data));
            nmie = m_mie; nmpie = m_mpie;
            ntvec = m_mtvec; nscr = m_mscratch;
            nepc = m_mepc; ncause = m_mcause; ntval = m_mtval;
            cyc = m_cyc + 1;
            ins = m_ins + (i_retire ? 64'd1 : 64'd0);
            if (w) begin
                case (i_adr)
                    12'h300: begin nmie = wd[3]; nmpie = wd[7]; end
                    12'h305: ntvec = (wd[1:0] >= 2) ?
                                     ((wd & ~32'h3) | (m_mtvec & 32'h3)) : wd;
                    12'h340: nscr = wd;
                    12'h341: nepc = wd & ~32'h3;
                    12'h342: ncause = wd;
                    12'h343: ntval = wd;
`ifdef CSR_COUNTERS_EN
                    12'hB00: cyc = (m_cyc & 64'hFFFFFFFF_00000000) | wd;
                    12'hB80: cyc = (m_cyc & 64'h00000000_FFFFFFFF) | (longint'(wd) << 32);
                    12'hB02: ins = (m_ins & 64'hFFFFFFFF_00000000) | wd;
                    12'hB82: ins = (m_ins & 64'h00000000_FFFFFFFF) | (longint'(wd) << 32);
`endif
                    default: ;
                endcase
            end
            if (i_mret) begin nmie = m_mpie; nmpie = 1; end
            if (i_trap) begin
                nepc = i_trap_pc & ~32'h3;
                ncause = i_trap_cause;
                ntval = i_trap_val;
                nmpie = m_mie;
                nmie = 0;
            end
            m_mie <= nmie; m_mpie <= nmpie;
            m_mtvec <= ntvec; m_mscratch <= nscr;
            m_mepc <= nepc; m_mcause <= ncause; m_mtval <= ntval;
            m_cyc <= cyc; m_ins <= ins;
        end
    end

    always @(negedge clk) begin
        logic [32:0] r;
        if (chk_en) begin
            r = mread(i_adr);
            cmp("rd_data", o_rd_data, r[31:0]);
            cmp("illegal", {31'd0, o_illegal}, {31'd0, exp_illegal()});
            cmp("mtvec", o_mtvec, i_rst ? 32'h0 : m_mtvec);
            cmp("mepc", o_mepc, i_rst ? 32'h0 : m_mepc);
            cmp("mie", {31'd0, o_mie}, {31'd0, (!i_rst && m_mie)});
        end
    end

    task automatic op(input bit rd, input bit wr, input bit st, input bit cl,
                      input logic [11:0] a, input logic [31:0] d,
                      input bit tr = 0, input bit mr = 0);
        @(posedge clk);
        #1;
        i_rst = 0;
        i_rd = rd; i_wr = wr; i_set = st; i_clr = cl;
        i_adr = a; i_wr_data = d;
        i_trap = tr; i_mret = mr; i_retire = 0;
    endtask

    initial begin
        i_rst = 1; i_rd = 0; i_wr = 0; i_set = 0; i_clr = 0;
        i_adr = 0; i_wr_data = 0; i_retire = 0; i_trap = 0; i_mret = 0;
        i_trap_pc = 0; i_trap_cause = 0; i_trap_val = 0;
        @(negedge clk);
        cmp("rst_mtvec", o_mtvec, 32'h0);
        cmp("rst_mie", {31'd0, o_mie}, 32'h0);
        repeat (2) @(posedge clk);
        chk_en = 1;

        op(1, 0, 0, 0, 12'h300, 0);
        @(negedge clk);
        cmp("lit_mstatus", o_rd_data, 32'h00001800);
        cmp("lit_ill0", {31'd0, o_illegal}, 32'h0);
        op(1, 0, 0, 0, 12'h305, 0);
        @(negedge clk);
        cmp("lit_mtvec", o_rd_data, 32'h0);

        op(0, 1, 0, 0, 12'h340, 32'hA5A5A5A5);
        op(0, 0, 1, 0, 12'h340, 32'h0000000F);
        op(0, 0, 0, 1, 12'h340, 32'hA0000000);
        op(1, 0, 0, 0, 12'h340, 0);
        @(negedge clk);
        cmp("lit_mscratch", o_rd_data, 32'h05A5A5AF);

        op(0, 0, 1, 0, 12'h300, 32'h8);
        i_trap_pc = 32'h00001236; i_trap_cause = 32'hB; i_trap_val = 32'h55;
        op(0, 0, 0, 0, 12'h000, 0, 1, 0);
        op(1, 0, 0, 0, 12'h341, 0);
        @(negedge clk);
        cmp("lit_mepc", o_rd_data, 32'h00001234);
        cmp("lit_mepc_o", o_mepc, 32'h00001234);
        cmp("lit_mie_trap", {31'd0, o_mie}, 32'h0);
        op(1, 0, 0, 0, 12'h342, 0);
        @(negedge clk);
        cmp("lit_mcause", o_rd_data, 32'hB);
        op(1, 0, 0, 0, 12'h300, 0);
        @(negedge clk);
        cmp("lit_mst_trap", o_rd_data, 32'h00001880);
        op(0, 0, 0, 0, 12'h000, 0, 0, 1);
        op(1, 0, 0, 0, 12'h300, 0);
        @(negedge clk);
        cmp("lit_mst_mret", o_rd_data, 32'h00001888);
        cmp("lit_mie_mret", {31'd0, o_mie}, 32'h1);

        op(0, 1, 0, 0, 12'hF14, 32'h5);
        @(negedge clk);
        cmp("lit_ro_ill", {31'd0, o_illegal}, 32'h1);
        op(1, 0, 0, 0, 12'hF14, 0);
        @(negedge clk);
        cmp("lit_hartid", o_rd_data, 32'h0);
        op(0, 0, 1, 0, 12'hF14, 0);
        @(negedge clk);
        cmp("lit_ro_set0", {31'd0, o_illegal}, 32'h0);
        op(1, 0, 0, 0, 12'h7C0, 0);
        @(negedge clk);
        cmp("lit_unimpl_ill", {31'd0, o_illegal}, 32'h1);
        cmp("lit_unimpl_rd", o_rd_data, 32'h0);

        i_trap_pc = 32'h00002000;
        op(0, 1, 0, 0, 12'h341, 32'h100, 1, 0);
        op(1, 0, 0, 0, 12'h341, 0);
        @(negedge clk);
        cmp("lit_trap_wins", o_rd_data, 32'h00002000);

`ifdef CSR_COUNTERS_EN
        op(0, 1, 0, 0, 12'hB00, 32'hFFFFFFFF);
        op(0, 1, 0, 0, 12'hB80, 32'hFFFFFFFF);
        op(1, 0, 0, 0, 12'hB80, 0);
        @(negedge clk);
        cmp("lit_cyc_hi", o_rd_data, 32'hFFFFFFFF);
        op(1, 0, 0, 0, 12'hB00, 0);
        @(negedge clk);
        cmp("lit_cyc_wrap_lo", o_rd_data, 32'h0);
        op(1, 0, 0, 0, 12'hB80, 0);
        @(negedge clk);
        cmp("lit_cyc_wrap_hi", o_rd_data, 32'h0);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic [11:0] a;
            logic [31:0] d;
            int k, sel;
            logic [11:0] alist [13];
            alist = '{12'h300, 12'h301, 12'hF14, 12'h305, 12'h340, 12'h341,
                      12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                      12'h344};
            k = $urandom_range(0, 15);
            a = (k < 13) ? alist[k] : 12'($urandom_range(0, 4095));
            d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 7) == 0)
                d = d | 32'hFFFFFFF0;
            sel = $urandom_range(0, 4);
            i_trap_pc = $urandom;
            i_trap_cause = $urandom;
            i_trap_val = $urandom;
            op(sel == 0, sel == 1, sel == 2, sel == 3, a, d,
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            i_retire = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0)
                i_rst = 1;
        end

        op(0, 0, 0, 0, 12'h000, 0);
        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
